// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes, funct codes, ALU ops.
// ADDI states exist only when MC_CTRL_ADDI_EN is defined.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
`ifdef MC_CTRL_ADDI_EN
        S_ADDIEX,
        S_ADDIWB,
`endif
        S_JUMP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/Funct to ALUControl decode; flags funct codes the ALU does not implement.
module alu_decoder
    import mc_pkg::*;
(
    input  aluop_t      alu_op,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_control,
    output logic        funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: begin
                        alu_control   = ALU_ADD;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore FSM sequencing the multicycle MIPS datapath; write enables are gated off while reset_n is low.
// addi support (ADDIEX/ADDIWB) is built only when MC_CTRL_ADDI_EN is defined.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  PCSrc,
    output logic        PCEn,
    output logic        Illegal
);

    state_t state;
    state_t state_nxt;
    aluop_t alu_op;
    logic   mem_write;
    logic   ir_write;
    logic   reg_write;
    logic   pc_write;
    logic   branch;
    logic   op_illegal;
    logic   funct_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        IorD       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        reg_write  = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_op     = ALUOP_ADD;
        op_illegal = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                ALUSrcB   = 2'b01;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // ALU computes the branch target speculatively while Op is decoded
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BRANCH;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_nxt = S_ADDIEX;
`endif
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        op_illegal = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD      = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                MemtoReg  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA   = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                RegDst    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                alu_op    = ALUOP_SUB;
                PCSrc     = 2'b01;
                branch    = 1'b1;
                state_nxt = S_FETCH;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
`endif
            S_JUMP: begin
                PCSrc     = 2'b10;
                pc_write  = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (Funct),
        .alu_control   (ALUControl),
        .funct_illegal (funct_illegal)
    );

    // Side-effecting strobes drop the moment reset_n falls, not at the next edge
    assign MemWrite = reset_n & mem_write;
    assign IRWrite  = reset_n & ir_write;
    assign RegWrite = reset_n & reg_write;
    assign PCEn     = reset_n & (pc_write | (branch & Zero));
    assign Illegal  = reset_n & (op_illegal | ((state == S_EXECUTE) & funct_illegal));

endmodule
